// File: rtl/imem_scrub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_scrub_pkg                                                       |
// | Shared types and MISR constants for the instruction-memory scrubber. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package imem_scrub_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SCRUB = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] din);
        return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ din;
    endfunction

endpackage
`default_nettype wire

// File: rtl/misr32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | misr32                                                               |
// | 32-bit multiple-input signature register, also used by ALU BIST.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module misr32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] sig
);
    import imem_scrub_pkg::*;

    logic [31:0] r_sig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= MISR_SEED;
        end else if (clr) begin
            r_sig <= MISR_SEED;
        end else if (en) begin
            r_sig <= misr_step(r_sig, din);
        end
    end

    assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/imem_scrubber.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_scrubber                                                        |
// | Sweeps ECC-protected imem, writes back corrected words, counts       |
// | single/double errors and signs all read data with a MISR.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_scrubber #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    input  logic        rd_s_err,
    input  logic        rd_d_err,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  sec_count,
    output logic [7:0]  ded_count,
    output logic        ded_fail,
    output logic [31:0] first_ded_addr,
    output logic [31:0] signature
);
    import imem_scrub_pkg::*;

    localparam logic [31:0] c_last_addr = BASE_ADDR + 32'(4 * (DEPTH - 1));

    state_t      r_state;
    state_t      w_next;
    logic        r_start_q;
    logic        r_arm;
    logic [31:0] r_addr;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic [7:0]  r_sec;
    logic [7:0]  r_ded;
    logic        r_ded_fail;
    logic [31:0] r_first_ded;

    logic w_start_edge;
    logic w_accept;
    logic w_at_last;
    logic w_check;
    logic w_advance;

    // r_arm blocks a start that was already high when reset released.
    assign w_start_edge = start & ~r_start_q & r_arm;
    assign w_accept     = w_start_edge & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_at_last    = (r_addr == c_last_addr);
    assign w_check      = (r_state == ST_CHECK);
    assign w_advance    = (w_check & (rd_d_err | ~rd_s_err)) | (r_state == ST_SCRUB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_accept) w_next = ST_READ;
            ST_READ:          w_next = ST_CHECK;
            ST_CHECK: begin
                if (!rd_d_err && rd_s_err) w_next = ST_SCRUB;
                else                       w_next = w_at_last ? ST_DONE : ST_READ;
            end
            ST_SCRUB:         w_next = w_at_last ? ST_DONE : ST_READ;
            default:          w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_en = (r_state == ST_READ);
        wr_en = (r_state == ST_SCRUB);
        busy  = (r_state == ST_READ) | (r_state == ST_CHECK) | (r_state == ST_SCRUB);
        done  = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_q   <= 1'b0;
            r_arm       <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_wr_addr   <= BASE_ADDR;
            r_wr_data   <= 32'h0;
            r_sec       <= 8'h0;
            r_ded       <= 8'h0;
            r_ded_fail  <= 1'b0;
            r_first_ded <= 32'h0;
        end else begin
            r_start_q <= start;
            r_arm     <= r_arm | ~start;
            if (w_accept) begin
                r_addr      <= BASE_ADDR;
                r_sec       <= 8'h0;
                r_ded       <= 8'h0;
                r_ded_fail  <= 1'b0;
                r_first_ded <= 32'h0;
            end else if (w_advance && !w_at_last) begin
                r_addr <= r_addr + 32'd4;
            end
            // rd_data and flags are only looked at in CHECK, so X elsewhere is harmless.
            if (w_check) begin
                if (rd_d_err) begin
                    r_ded      <= (r_ded == 8'hFF) ? r_ded : r_ded + 8'd1;
                    r_ded_fail <= 1'b1;
                    if (!r_ded_fail) r_first_ded <= r_addr;
                end else if (rd_s_err) begin
                    r_sec     <= (r_sec == 8'hFF) ? r_sec : r_sec + 8'd1;
                    r_wr_addr <= r_addr;
                    r_wr_data <= rd_data;
                end
            end
        end
    end

    misr32 u_misr (
        .clk (clk),
        .rst (rst),
        .clr (w_accept),
        .en  (w_check),
        .din (rd_data),
        .sig (signature)
    );

    assign rd_addr        = r_addr;
    assign wr_addr        = r_wr_addr;
    assign wr_data        = r_wr_data;
    assign sec_count      = r_sec;
    assign ded_count      = r_ded;
    assign ded_fail       = r_ded_fail;
    assign first_ded_addr = r_first_ded;

endmodule
`default_nettype wire

// File: tb/tb_imem_scrubber.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_scrubber                                                     |
// | Directed self-checking bench for imem_scrubber (DEPTH=4 and 300).    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_imem_scrubber;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic        start = 1'b0;
    logic        rd_en, wr_en, busy, done, ded_fail;
    logic [31:0] rd_addr, wr_addr, wr_data, first_ded_addr, signature;
    logic [31:0] rd_data = 32'h0;
    logic        rd_s_err = 1'b0, rd_d_err = 1'b0;
    logic [7:0]  sec_count, ded_count;

    // DEPTH=300 instance
    logic        start300 = 1'b0;
    logic        rd_en300, wr_en300, busy300, done300, ded_fail300;
    logic [31:0] rd_addr300, wr_addr300, wr_data300, first_ded_addr300, signature300;
    logic [31:0] rd_data300 = 32'h0;
    logic        rd_s_err300 = 1'b0, rd_d_err300 = 1'b0;
    logic [7:0]  sec_count300, ded_count300;

    imem_scrubber #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_s_err(rd_s_err), .rd_d_err(rd_d_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .sec_count(sec_count), .ded_count(ded_count),
        .ded_fail(ded_fail), .first_ded_addr(first_ded_addr), .signature(signature)
    );

    imem_scrubber #(.DEPTH(300), .BASE_ADDR(32'h0)) dut300 (
        .clk(clk), .rst(rst), .start(start300),
        .rd_en(rd_en300), .rd_addr(rd_addr300), .rd_data(rd_data300),
        .rd_s_err(rd_s_err300), .rd_d_err(rd_d_err300),
        .wr_en(wr_en300), .wr_addr(wr_addr300), .wr_data(wr_data300),
        .busy(busy300), .done(done300), .sec_count(sec_count300), .ded_count(ded_count300),
        .ded_fail(ded_fail300), .first_ded_addr(first_ded_addr300), .signature(signature300)
    );

    logic [31:0] mem [0:3];
    logic        serr [0:3];
    logic        derr [0:3];

    // Memory models: data one cycle after rd_en, X otherwise.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data  <= mem[rd_addr[3:2]];
            rd_s_err <= serr[rd_addr[3:2]];
            rd_d_err <= derr[rd_addr[3:2]];
        end else begin
            rd_data  <= 'x;
            rd_s_err <= 1'b0;
            rd_d_err <= 1'b0;
        end
        rd_data300  <= rd_en300 ? (rd_addr300 ^ 32'h5A5A0000) : 'x;
        rd_s_err300 <= rd_en300;
        rd_d_err300 <= 1'b0;
    end

    int          rd_n = 0, wr_n = 0, wr_n300 = 0, both_n = 0;
    logic [31:0] rd_log [0:63];
    logic [31:0] wa_log [0:63];
    logic [31:0] wd_log [0:63];

    always @(negedge clk) begin
        if (rd_en) begin
            if (rd_n < 64) rd_log[rd_n] = rd_addr;
            rd_n = rd_n + 1;
        end
        if (wr_en) begin
            if (wr_n < 64) begin
                wa_log[wr_n] = wr_addr;
                wd_log[wr_n] = wr_data;
            end
            wr_n = wr_n + 1;
        end
        if (wr_en300) wr_n300 = wr_n300 + 1;
        if ((rd_en && wr_en) || (rd_en300 && wr_en300)) both_n = both_n + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sig_model();
        logic [31:0] s;
        s = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++)
            s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ mem[i];
        return s;
    endfunction

    // Raise start at a negedge, count rising edges until done is seen.
    task automatic sweep4(input bit glitch, output int cyc);
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (glitch && cyc == 3) start = 1'b0;
            if (glitch && cyc == 4) start = 1'b1;
            if (done || cyc > 200) break;
        end
        start = 1'b0;
    endtask

    task automatic set_errs(input logic [3:0] s, input logic [3:0] d);
        for (int i = 0; i < 4; i++) begin
            serr[i] = s[i];
            derr[i] = d[i];
        end
    endtask

    int cyc, rd0, wr0, k;
    logic [31:0] exp_sig;

    initial begin
        mem[0] = 32'h00500093;
        mem[1] = 32'h00300113;
        mem[2] = 32'h002081B3;
        mem[3] = 32'h00000013;
        set_errs(4'b0000, 4'b0000);
        exp_sig = sig_model();

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_rd_en", {31'b0, rd_en}, 32'h0);
        check("rst_sig", signature, 32'hFFFFFFFF);
        check("rst_sec", {24'b0, sec_count}, 32'h0);
        check("rst_rd_addr", rd_addr, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean sweep
        rd0 = rd_n; wr0 = wr_n;
        sweep4(1'b0, cyc);
        check("clean_cycles", cyc, 9);
        check("clean_rd_n", rd_n - rd0, 4);
        for (int i = 0; i < 4; i++) check("clean_rd_addr", rd_log[rd0 + i], 32'(4 * i));
        check("clean_wr_n", wr_n - wr0, 0);
        check("clean_sec", {24'b0, sec_count}, 32'h0);
        check("clean_ded", {24'b0, ded_count}, 32'h0);
        check("clean_sig", signature, exp_sig);
        check("clean_busy", {31'b0, busy}, 32'h0);

        // Single-bit error on word 1
        set_errs(4'b0010, 4'b0000);
        rd0 = rd_n; wr0 = wr_n;
        sweep4(1'b0, cyc);
        check("sec_cycles", cyc, 10);
        check("sec_wr_n", wr_n - wr0, 1);
        check("sec_wr_addr", wa_log[wr0], 32'h4);
        check("sec_wr_data", wd_log[wr0], 32'h00300113);
        check("sec_count", {24'b0, sec_count}, 32'h1);
        check("sec_sig", signature, exp_sig);

        // Double-bit errors on words 2 and 3 (restart from DONE clears sec_count)
        set_errs(4'b1000, 4'b1100);
        rd0 = rd_n; wr0 = wr_n;
        sweep4(1'b0, cyc);
        check("ded_cycles", cyc, 9);
        check("ded_count", {24'b0, ded_count}, 32'h2);
        check("ded_fail", {31'b0, ded_fail}, 32'h1);
        check("ded_first", first_ded_addr, 32'h8);
        check("ded_wr_n", wr_n - wr0, 0);
        check("ded_sec", {24'b0, sec_count}, 32'h0);

        // Second start edge mid-sweep is ignored; restart clears ded state
        set_errs(4'b0000, 4'b0000);
        rd0 = rd_n;
        sweep4(1'b1, cyc);
        check("glitch_cycles", cyc, 9);
        check("glitch_rd_n", rd_n - rd0, 4);
        check("glitch_ded", {24'b0, ded_count}, 32'h0);
        check("glitch_ded_fail", {31'b0, ded_fail}, 32'h0);
        check("glitch_sig", signature, exp_sig);
        repeat (4) @(negedge clk);
        check("glitch_stay_done", {31'b0, done}, 32'h1);

        // Reset during CHECK of word 2, start held through release
        set_errs(4'b0001, 4'b0000);
        @(negedge clk);
        start = 1'b1;
        k = 0;
        while (!(rd_en && rd_addr == 32'h8) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("mid_reach_word2", {31'b0, rd_en}, 32'h1);
        @(negedge clk);
        check("mid_pre_sec", {24'b0, sec_count}, 32'h1);
        rst = 1'b1;
        #1;
        check("mid_busy", {31'b0, busy}, 32'h0);
        check("mid_done", {31'b0, done}, 32'h0);
        check("mid_rd_en", {31'b0, rd_en}, 32'h0);
        check("mid_wr_en", {31'b0, wr_en}, 32'h0);
        check("mid_sec", {24'b0, sec_count}, 32'h0);
        check("mid_sig", signature, 32'hFFFFFFFF);
        check("mid_rd_addr", rd_addr, 32'h0);
        check("mid_wr_addr", wr_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd0 = rd_n;
        repeat (6) @(negedge clk);
        check("held_no_sweep", rd_n - rd0, 0);
        check("held_busy", {31'b0, busy}, 32'h0);
        start = 1'b0;
        sweep4(1'b0, cyc);
        check("fresh_cycles", cyc, 10);
        check("fresh_sec", {24'b0, sec_count}, 32'h1);

        // 300 words, all single-bit errors
        wr0 = wr_n300;
        @(negedge clk);
        start300 = 1'b1;
        cyc = 0;
        while (!done300 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        start300 = 1'b0;
        check("d300_cycles", cyc, 901);
        check("d300_sec_sat", {24'b0, sec_count300}, 32'd255);
        check("d300_wr_n", wr_n300 - wr0, 300);
        check("d300_ded", {24'b0, ded_count300}, 32'h0);

        check("no_rd_wr_overlap", both_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
